// File: rtl/matriz_pkg.sv
// Shared constants, scan state type and one-hot helpers for the LED matrix driver.
package matriz_pkg;

  localparam logic [7:0]  MODE_SET = 8'h80;
  localparam logic [7:0]  MODE_CLR = 8'h40;
  localparam int unsigned N_ROWS   = 8;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic logic is_onehot8(input logic [7:0] v);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) ones++;
    end
    return (ones == 1);
  endfunction

  // Position of the set bit; only meaningful when is_onehot8() holds.
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] row_sel(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/matriz_scan_driver_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/matriz_scan_driver.sv
// Commits decoded set/clear commands into an 8x8 frame buffer and scans it onto
// the LED matrix one row at a time with blanking between rows.
module matriz_scan_driver
  import matriz_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] modo,
  input  logic [7:0] linha,
  input  logic [7:0] coluna,
  input  logic       confirma,
  output logic [7:0] row_n,
  output logic [7:0] col,
  output logic       erro
);

  localparam int unsigned MAXC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ROW_LAST   = cnt_t'(ROW_CYCLES - 1);
  localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);

  logic                        commit;
  logic                        cmd_valid;
  logic [N_ROWS-1:0][7:0]      frame;
  scan_state_t                 state, state_nxt;
  cnt_t                        cnt, cnt_nxt;
  logic [2:0]                  row_idx, row_nxt;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (confirma),
    .pulse (commit)
  );

  assign cmd_valid = ((modo == MODE_SET) || (modo == MODE_CLR)) &&
                     is_onehot8(linha) && is_onehot8(coluna);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
      erro  <= 1'b0;
    end else begin
      erro <= commit & ~cmd_valid;
      if (commit && cmd_valid)
        frame[onehot_idx(linha)][onehot_idx(coluna)] <= (modo == MODE_SET);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + cnt_t'(1);
    row_nxt   = row_idx;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == ROW_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          row_nxt   = row_idx + 3'd1;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so the pins line up with
  // the state register instead of lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      cnt     <= '0;
      row_idx <= '0;
      row_n   <= '1;
      col     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      row_idx <= row_nxt;
      if (state_nxt == DRIVE) begin
        row_n <= ~row_sel(row_nxt);
        col   <= frame[row_nxt];
      end else begin
        row_n <= '1;
        col   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matriz_scan_driver.sv
// Scoreboard bench for matriz_scan_driver with ROW_CYCLES=4, BLANK_CYCLES=1.
module tb_matriz_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] modo, linha, coluna;
  logic       confirma;
  logic [7:0] row_n, col;
  logic       erro;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         c;
    logic [2:0] r;
    logic [2:0] k;
    logic       v;
  } wr_t;

  wr_t        wq[$];
  int         eq[$];
  logic [7:0] mframe [8];

  matriz_scan_driver #(.ROW_CYCLES(4), .BLANK_CYCLES(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .modo     (modo),
    .linha    (linha),
    .coluna   (coluna),
    .confirma (confirma),
    .row_n    (row_n),
    .col      (col),
    .erro     (erro)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int oh_pos(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  // Scan reference: after edge n of the run, n%5==0 is a blank slot, otherwise
  // row (n/5)%8 is driven with the frame as it stood before that edge.
  initial begin
    logic [7:0] er, ec;
    int         row;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = 0;
        continue;
      end
      cyc++;
      if (cyc % 5 == 0) begin
        er = 8'hFF;
        ec = 8'h00;
      end else begin
        row = (cyc / 5) % 8;
        er  = ~(8'h01 << row);
        ec  = mframe[row];
      end
      while (wq.size() > 0 && wq[0].c == cyc) begin
        wr_t w;
        w = wq.pop_front();
        mframe[w.r][w.k] = w.v;
      end
      #1;
      if (rst_n) begin
        check("row_n", {24'd0, row_n}, {24'd0, er});
        check("col", {24'd0, col}, {24'd0, ec});
        if (erro === 1'b1) begin
          if (eq.size() == 0) check("erro_spurious", 32'd1, 32'd0);
          else check("erro_cyc", cyc, eq.pop_front());
        end else if (eq.size() > 0 && eq[0] < cyc) begin
          check("erro_missed", cyc, eq.pop_front());
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] m, input logic [7:0] l, input logic [7:0] k,
                       input int hold);
    int  c0;
    wr_t w;
    @(negedge clk);
    c0     = cyc;
    modo   = m;
    linha  = l;
    coluna = k;
    if ((m == 8'h80 || m == 8'h40) && ones(l) == 1 && ones(k) == 1) begin
      w.c = c0 + 4;
      w.r = 3'(oh_pos(l));
      w.k = 3'(oh_pos(k));
      w.v = (m == 8'h80);
      wq.push_back(w);
    end else begin
      eq.push_back(c0 + 4);
    end
    confirma = 1'b1;
    run(hold);
    confirma = 1'b0;
    run(8);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 8; i++) mframe[i] = 8'h00;
    rst_n    = 1'b0;
    confirma = 1'b0;
    modo     = 8'h00;
    linha    = 8'h00;
    coluna   = 8'h00;
    run(3);
    check("rst_row_n", {24'd0, row_n}, 32'hFF);
    check("rst_col", {24'd0, col}, 32'h00);
    check("rst_erro", {31'd0, erro}, 32'd0);
    rst_n = 1'b1;

    run(45);                                   // blank frame scan
    press(8'h80, 8'h20, 8'h04, 3);             // set (5,2)
    run(45);
    press(8'h40, 8'h20, 8'h04, 3);             // clear (5,2)
    run(45);
    press(8'h80, 8'h20, 8'h04, 3);
    press(8'h80, 8'h20, 8'h01, 3);             // row 5 shows 05
    run(45);
    press(8'hC0, 8'h20, 8'h04, 3);             // invalid mode
    press(8'h80, 8'h30, 8'h04, 3);             // two rows
    press(8'h80, 8'h20, 8'h00, 3);             // no column
    run(45);
    press(8'h80, 8'h01, 8'h80, 100);           // level-held button
    run(45);

    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (row_n == 8'hF7) found = 1;
    end
    check("wait_row3", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    wq.delete();
    eq.delete();
    for (int i = 0; i < 8; i++) mframe[i] = 8'h00;
    cyc = 0;
    #1;
    check("async_row_n", {24'd0, row_n}, 32'hFF);
    check("async_col", {24'd0, col}, 32'h00);
    check("async_erro", {31'd0, erro}, 32'd0);
    run(2);
    rst_n = 1'b1;
    run(90);                                   // frame must come back all zero

    check("wq_drained", wq.size(), 32'd0);
    check("eq_drained", eq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
